// File: rtl/uart_tx_arbiter_if.sv
// Requester/transmitter bundle for uart_tx_arbiter.
//   req_valid/req_data/req_ready : per-requester byte handshake
//   tx_data/tx_request           : drive the shared uart_tx instance
//   busy/grant_id/frame_done     : frame ownership status
// slave modport is the arbiter side; master modport is the producer/observer side.
interface uart_tx_arbiter_if #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned DATA_BITS = 8
);
  localparam int unsigned ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]           req_valid;
  logic [NUM_REQ*DATA_BITS-1:0] req_data;
  logic [NUM_REQ-1:0]           req_ready;
  logic [DATA_BITS-1:0]         tx_data;
  logic                         tx_request;
  logic                         busy;
  logic [ID_W-1:0]              grant_id;
  logic                         frame_done;

  modport slave (
    input  req_valid, req_data,
    output req_ready, tx_data, tx_request, busy, grant_id, frame_done
  );

  modport master (
    output req_valid, req_data,
    input  req_ready, tx_data, tx_request, busy, grant_id, frame_done
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx between NUM_REQ byte sources.
// The transmitter has no busy/done output, so each frame is timed here:
// tx_request is held for one baud period (one sample by the free-running
// baud tick), then the window runs out the start/data/stop bits.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   enable       : gates new grants only; an in-flight frame completes
//   bus          : uart_tx_arbiter_if.slave (handshake + transmitter drive)
module uart_tx_arbiter #(
  parameter int unsigned CLK_FREQUENCY = 100_000_000,
  parameter int unsigned BAUD_RATE     = 115200,
  parameter int unsigned DATA_BITS     = 8,
  parameter int unsigned NUM_REQ       = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  uart_tx_arbiter_if.slave  bus
);

  localparam int unsigned BAUD_DIV = CLK_FREQUENCY / BAUD_RATE;
  localparam int unsigned HOLD_LEN = BAUD_DIV;
  localparam int unsigned WIN_LEN  = (DATA_BITS + 4) * BAUD_DIV;
  localparam int unsigned CNT_W    = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;
  localparam int unsigned ID_W     = $clog2(NUM_REQ);

  typedef enum logic [1:0] {IDLE, HOLD, WAIT} state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [ID_W-1:0]      ptr_q, ptr_d;
  logic [ID_W-1:0]      grant_q, grant_d;
  logic [DATA_BITS-1:0] tx_data_q, tx_data_d;
  logic                 tx_req_q, tx_req_d;
  logic                 busy_q, busy_d;
  logic                 fd_q, fd_d;
  logic [NUM_REQ-1:0]   ready_c;

  logic                 win_found;
  logic [ID_W-1:0]      win_idx;
  logic [ID_W-1:0]      cand;

  // Round-robin search: first valid index after the pointer, modulo NUM_REQ.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = ID_W'((32'(ptr_q) + k) % NUM_REQ);
      if (!win_found && bus.req_valid[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ptr_d     = ptr_q;
    grant_d   = grant_q;
    tx_data_d = tx_data_q;
    tx_req_d  = tx_req_q;
    busy_d    = busy_q;
    fd_d      = 1'b0;
    ready_c   = '0;
    case (state_q)
      IDLE: begin
        // reset_n gates ready so the combinational accept is silent while in reset.
        if (reset_n && enable && win_found) begin
          ready_c[win_idx] = 1'b1;
          tx_data_d        = bus.req_data[32'(win_idx) * DATA_BITS +: DATA_BITS];
          grant_d          = win_idx;
          ptr_d            = win_idx;
          tx_req_d         = 1'b1;
          busy_d           = 1'b1;
          cnt_d            = '0;
          state_d          = HOLD;
        end
      end
      HOLD: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(HOLD_LEN - 1)) begin
          tx_req_d = 1'b0;
          state_d  = WAIT;
        end
      end
      WAIT: begin
        // tx_data stays put: the transmitter latches it a baud tick after the request.
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIN_LEN - 1)) begin
          busy_d  = 1'b0;
          fd_d    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; RR pointer resets to the last index so requester 0 leads.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      ptr_q     <= ID_W'(NUM_REQ - 1);
      grant_q   <= '0;
      tx_data_q <= '0;
      tx_req_q  <= 1'b0;
      busy_q    <= 1'b0;
      fd_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ptr_q     <= ptr_d;
      grant_q   <= grant_d;
      tx_data_q <= tx_data_d;
      tx_req_q  <= tx_req_d;
      busy_q    <= busy_d;
      fd_q      <= fd_d;
    end
  end

  assign bus.req_ready  = ready_c;
  assign bus.tx_data    = tx_data_q;
  assign bus.tx_request = tx_req_q;
  assign bus.busy       = busy_q;
  assign bus.grant_id   = grant_q;
  assign bus.frame_done = fd_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: BAUD_DIV=10, 8 data bits, 4 requesters,
// 120-cycle frame window. Expected grants are queued when stimulus is applied and
// compared against grant_id/tx_data on every tx_request rising edge.
module tb_uart_tx_arbiter;

  localparam int unsigned NR = 4;
  localparam int unsigned DB = 8;

  typedef struct packed {
    logic [1:0] id;
    logic [7:0] data;
  } exp_t;

  logic clk;
  logic reset_n;
  logic enable;

  uart_tx_arbiter_if #(.NUM_REQ(NR), .DATA_BITS(DB)) bus ();

  uart_tx_arbiter #(
    .CLK_FREQUENCY(100),
    .BAUD_RATE    (10),
    .DATA_BITS    (DB),
    .NUM_REQ      (NR)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .enable (enable),
    .bus    (bus)
  );

  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  exp_t exp_q[$];
  int   rise_q[$];
  logic prev_req = 1'b0;
  exp_t e;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: every new frame must match the oldest queued grant.
  always @(negedge clk) begin
    if (reset_n && bus.tx_request && !prev_req) begin
      rise_q.push_back(cyc);
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected_grant grant_id=%0d tx_data=%h required=none",
                 bus.grant_id, bus.tx_data);
      end else begin
        e = exp_q.pop_front();
        if (bus.grant_id !== e.id || bus.tx_data !== e.data) begin
          failures++;
          $display("FAIL sb_grant grant_id=%0d tx_data=%h required id=%0d data=%h",
                   bus.grant_id, bus.tx_data, e.id, e.data);
        end
      end
    end
    prev_req = bus.tx_request;
  end

  task automatic expect_grant(input logic [1:0] id, input logic [7:0] d);
    exp_q.push_back({id, d});
  endtask

  task automatic set_data(input int i, input logic [7:0] d);
    bus.req_data[i*DB +: DB] = d;
  endtask

  task automatic do_reset();
    reset_n       = 1'b0;
    enable        = 1'b1;
    bus.req_valid = '0;
    bus.req_data  = '0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    rise_q.delete();
  endtask

  // Bounded wait for a grant; returns in the accepting cycle (before its edge).
  task automatic wait_ready(input int limit, output logic [3:0] r);
    r = '0;
    for (int k = 0; k < limit; k++) begin
      #1;
      if (bus.req_ready != 0) begin
        r = bus.req_ready;
        return;
      end
      @(negedge clk);
    end
    checks++;
    failures++;
    $display("FAIL wait_ready_timeout ready=%b required=nonzero", bus.req_ready);
  endtask

  task automatic wait_idle(input int limit);
    for (int k = 0; k < limit; k++) begin
      @(negedge clk);
      if (!bus.busy) return;
    end
    checks++;
    failures++;
    $display("FAIL wait_idle_timeout busy=%b required=0", bus.busy);
  endtask

  task automatic test_reset();
    reset_n       = 1'b0;
    enable        = 1'b1;
    bus.req_valid = 4'b1111;
    bus.req_data  = 32'h44332211;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (bus.tx_request !== 1'b0) begin failures++; $display("FAIL reset_tx_request got=%b required=0", bus.tx_request); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b required=0", bus.busy); end
    checks++; if (bus.tx_data !== 8'h00) begin failures++; $display("FAIL reset_tx_data got=%h required=00", bus.tx_data); end
    checks++; if (bus.grant_id !== 2'd0) begin failures++; $display("FAIL reset_grant_id got=%0d required=0", bus.grant_id); end
    checks++; if (bus.frame_done !== 1'b0) begin failures++; $display("FAIL reset_frame_done got=%b required=0", bus.frame_done); end
    checks++; if (bus.req_ready !== 4'b0000) begin failures++; $display("FAIL reset_req_ready got=%b required=0000", bus.req_ready); end
  endtask

  task automatic test_single();
    int req_hi, busy_hi, fd_cnt, data_bad;
    do_reset();
    set_data(0, 8'hA5);
    bus.req_valid = 4'b0001;
    expect_grant(2'd0, 8'hA5);
    #1;
    checks++; if (bus.req_ready !== 4'b0001) begin failures++; $display("FAIL single_ready got=%b required=0001", bus.req_ready); end
    @(negedge clk);
    bus.req_valid = '0;
    req_hi = 0; busy_hi = 0; fd_cnt = 0; data_bad = 0;
    for (int k = 0; k < 130; k++) begin
      if (bus.tx_request) req_hi++;
      if (bus.busy) begin
        busy_hi++;
        if (bus.tx_data !== 8'hA5) data_bad++;
      end
      if (bus.frame_done) fd_cnt++;
      @(negedge clk);
    end
    checks++; if (req_hi != 10) begin failures++; $display("FAIL single_req_len got=%0d required=10", req_hi); end
    checks++; if (busy_hi != 120) begin failures++; $display("FAIL single_busy_len got=%0d required=120", busy_hi); end
    checks++; if (fd_cnt != 1) begin failures++; $display("FAIL single_frame_done got=%0d required=1", fd_cnt); end
    checks++; if (data_bad != 0) begin failures++; $display("FAIL single_data_stable got=%0d bad cycles required=0", data_bad); end
    checks++; if (bus.grant_id !== 2'd0) begin failures++; $display("FAIL single_grant_id got=%0d required=0", bus.grant_id); end
  endtask

  task automatic test_all_four();
    logic [3:0] r;
    logic [3:0] want;
    do_reset();
    bus.req_data  = 32'h44332211;
    bus.req_valid = 4'b1111;
    for (int i = 0; i < 4; i++) expect_grant(2'(i), 8'((i + 1) * 8'h11));
    for (int i = 0; i < 4; i++) begin
      wait_ready(300, r);
      want = 4'b0001 << i;
      checks++; if (r !== want) begin failures++; $display("FAIL all4_order idx=%0d got=%b required=%b", i, r, want); end
      @(negedge clk);
      bus.req_valid[i] = 1'b0;
    end
    wait_idle(200);
    checks++;
    if (rise_q.size() != 4) begin
      failures++; $display("FAIL all4_frames got=%0d required=4", rise_q.size());
    end else begin
      for (int i = 1; i < 4; i++) begin
        checks++;
        if (rise_q[i] - rise_q[i-1] != 121) begin
          failures++; $display("FAIL all4_spacing idx=%0d got=%0d required=121", i, rise_q[i] - rise_q[i-1]);
        end
      end
    end
  endtask

  task automatic test_fairness();
    logic [3:0] r;
    logic [3:0] want;
    logic [1:0] wid;
    do_reset();
    set_data(0, 8'h10);
    set_data(2, 8'h20);
    bus.req_valid = 4'b0101;
    expect_grant(2'd0, 8'h10); expect_grant(2'd2, 8'h20);
    expect_grant(2'd0, 8'h10); expect_grant(2'd2, 8'h20);
    for (int i = 0; i < 4; i++) begin
      wid  = (i % 2 == 0) ? 2'd0 : 2'd2;
      want = 4'b0001 << wid;
      wait_ready(300, r);
      checks++; if (r !== want) begin failures++; $display("FAIL fair_ready idx=%0d got=%b required=%b", i, r, want); end
      @(negedge clk);
      checks++; if (bus.grant_id !== wid) begin failures++; $display("FAIL fair_grant_id idx=%0d got=%0d required=%0d", i, bus.grant_id, wid); end
    end
    bus.req_valid = '0;
    wait_idle(200);
  endtask

  task automatic test_enable();
    int bad, fd_cnt;
    do_reset();
    enable = 1'b0;
    set_data(1, 8'h77);
    bus.req_valid = 4'b0010;
    bad = 0;
    for (int k = 0; k < 50; k++) begin
      #1;
      if (bus.req_ready !== 4'b0000 || bus.tx_request !== 1'b0) bad++;
      @(negedge clk);
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL enable_low_blocks got=%0d active cycles required=0", bad); end
    enable = 1'b1;
    expect_grant(2'd1, 8'h77);
    #1;
    checks++; if (bus.req_ready !== 4'b0010) begin failures++; $display("FAIL enable_rise_ready got=%b required=0010", bus.req_ready); end
    @(negedge clk);
    bus.req_valid = '0;
    enable = 1'b0;
    fd_cnt = 0;
    for (int k = 0; k < 130; k++) begin
      if (bus.frame_done) fd_cnt++;
      @(negedge clk);
    end
    checks++; if (fd_cnt != 1) begin failures++; $display("FAIL enable_drop_frame_done got=%0d required=1", fd_cnt); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL enable_drop_busy got=%b required=0", bus.busy); end
    enable = 1'b1;
  endtask

  task automatic test_reset_mid();
    logic [3:0] r;
    do_reset();
    set_data(3, 8'hC3);
    bus.req_valid = 4'b1000;
    expect_grant(2'd3, 8'hC3);
    wait_ready(5, r);
    @(negedge clk);
    repeat (59) @(negedge clk);
    reset_n = 1'b0;
    #1;
    checks++; if (bus.tx_request !== 1'b0) begin failures++; $display("FAIL midrst_tx_request got=%b required=0", bus.tx_request); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%b required=0", bus.busy); end
    checks++; if (bus.req_ready !== 4'b0000) begin failures++; $display("FAIL midrst_req_ready got=%b required=0000", bus.req_ready); end
    @(negedge clk);
    expect_grant(2'd3, 8'hC3);
    reset_n = 1'b1;
    #1;
    checks++; if (bus.req_ready !== 4'b1000) begin failures++; $display("FAIL midrst_regrant got=%b required=1000", bus.req_ready); end
    @(negedge clk);
    bus.req_valid = '0;
    wait_idle(200);
    // Grant req0 so the pointer sits at 0, then check reset returns priority to req0.
    @(negedge clk);
    set_data(0, 8'h3C);
    bus.req_valid = 4'b0001;
    expect_grant(2'd0, 8'h3C);
    wait_ready(5, r);
    @(negedge clk);
    bus.req_valid = '0;
    repeat (30) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    bus.req_valid = 4'b1001;
    expect_grant(2'd0, 8'h3C);
    reset_n = 1'b1;
    #1;
    checks++; if (bus.req_ready !== 4'b0001) begin failures++; $display("FAIL midrst_rr_ptr got=%b required=0001", bus.req_ready); end
    @(negedge clk);
    bus.req_valid = '0;
    wait_idle(200);
  endtask

  task automatic test_back_to_back();
    logic [3:0] r;
    int fd_cnt;
    do_reset();
    set_data(0, 8'hA5);
    bus.req_valid = 4'b0001;
    expect_grant(2'd0, 8'hA5);
    expect_grant(2'd0, 8'h5A);
    wait_ready(5, r);
    @(negedge clk);
    set_data(0, 8'h5A);
    fd_cnt = 0;
    r = '0;
    for (int k = 0; k < 200; k++) begin
      #1;
      if (bus.frame_done) fd_cnt++;
      if (bus.req_ready != 0) begin
        r = bus.req_ready;
        break;
      end
      @(negedge clk);
    end
    checks++; if (r !== 4'b0001) begin failures++; $display("FAIL b2b_regrant got=%b required=0001", r); end
    checks++; if (fd_cnt != 1) begin failures++; $display("FAIL b2b_frame_done got=%0d required=1", fd_cnt); end
    @(negedge clk);
    bus.req_valid = '0;
    wait_idle(200);
    checks++;
    if (rise_q.size() != 2) begin
      failures++; $display("FAIL b2b_frames got=%0d required=2", rise_q.size());
    end else if (rise_q[1] - rise_q[0] != 121) begin
      failures++; $display("FAIL b2b_spacing got=%0d required=121", rise_q[1] - rise_q[0]);
    end
  endtask

  initial begin
    reset_n       = 1'b0;
    enable        = 1'b1;
    bus.req_valid = '0;
    bus.req_data  = '0;
    test_reset();
    test_single();
    test_all_four();
    test_fairness();
    test_enable();
    test_reset_mid();
    test_back_to_back();
    repeat (5) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++; $display("FAIL sb_leftover got=%0d pending required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
